// File: rtl/huffman_decoder_pkg.sv
// Shared constants, state encodings and field types for the Huffman decoder.
// Optional per-symbol statistics are enabled with HUFF_DEC_STAT_EN.
package huffman_decoder_pkg;
    localparam int NSYM = 6;
    localparam int CW   = 8;
    localparam int LW   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    typedef logic [CW-1:0] code_t;
    typedef logic [LW-1:0] len_t;

    // Masks are contiguous ones from the LSB, so the popcount is the code length.
    function automatic len_t popcount(input code_t v);
        len_t c;
        c = '0;
        for (int i = 0; i < CW; i++) begin
            c = c + len_t'(v[i]);
        end
        return c;
    endfunction
endpackage

// File: rtl/huffman_dec_match.sv
// Combinational codeword matcher: shifts in one bit and compares against all table entries.
module huffman_dec_match
    import huffman_decoder_pkg::*;
(
    input  code_t       acc,
    input  len_t        len,
    input  logic        bit_in,
    input  len_t        max_len,
    input  code_t       hc [NSYM],
    input  code_t       mask [NSYM],
    input  len_t        lens [NSYM],
    output code_t       acc_next,
    output len_t        len_next,
    output logic        hit,
    output logic [2:0]  idx,
    output logic        miss
);
    logic [NSYM-1:0] eq;

    assign acc_next = {acc[CW-2:0], bit_in};
    assign len_next = len + len_t'(1);

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_cmp
            assign eq[gi] = (lens[gi] != '0) && (len_next == lens[gi]) &&
                            ((acc_next & mask[gi]) == (hc[gi] & mask[gi]));
        end
    endgenerate

    // Scan downwards so the lowest matching entry wins.
    always_comb begin
        idx = '0;
        for (int i = NSYM - 1; i >= 0; i--) begin
            if (eq[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign hit  = |eq;
    assign miss = !hit && (len_next == max_len);
endmodule

// File: rtl/huffman_decoder.sv
// Huffman decoder: loads a six-entry code table, then decodes an MSB-first bitstream into symbols 1..6.
// Define HUFF_DEC_STAT_EN to add saturating per-symbol decode counters SCNT1..SCNT6.
module huffman_decoder
    import huffman_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] HC1,
    input  logic [7:0] HC2,
    input  logic [7:0] HC3,
    input  logic [7:0] HC4,
    input  logic [7:0] HC5,
    input  logic [7:0] HC6,
    input  logic [7:0] M1,
    input  logic [7:0] M2,
    input  logic [7:0] M3,
    input  logic [7:0] M4,
    input  logic [7:0] M5,
    input  logic [7:0] M6,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       bit_ready,
    output logic       sym_valid,
    output logic [7:0] sym_data,
    output logic       dec_err
`ifdef HUFF_DEC_STAT_EN
    ,
    output logic [7:0] SCNT1,
    output logic [7:0] SCNT2,
    output logic [7:0] SCNT3,
    output logic [7:0] SCNT4,
    output logic [7:0] SCNT5,
    output logic [7:0] SCNT6
`endif
);
    logic [1:0] state_reg;
    code_t      acc_reg;
    len_t       len_reg;
    len_t       max_len_reg;
    logic       sym_valid_reg;
    logic [7:0] sym_data_reg;
    logic       dec_err_reg;

    code_t hc_in [NSYM];
    code_t m_in [NSYM];
    code_t hc_reg [NSYM];
    code_t m_reg [NSYM];
    len_t  len_tbl_reg [NSYM];
    len_t  max_in;

    code_t      acc_next;
    len_t       len_next;
    logic       hit;
    logic       miss;
    logic [2:0] idx;
    logic       accept;

    assign hc_in[0] = HC1;
    assign hc_in[1] = HC2;
    assign hc_in[2] = HC3;
    assign hc_in[3] = HC4;
    assign hc_in[4] = HC5;
    assign hc_in[5] = HC6;
    assign m_in[0]  = M1;
    assign m_in[1]  = M2;
    assign m_in[2]  = M3;
    assign m_in[3]  = M4;
    assign m_in[4]  = M5;
    assign m_in[5]  = M6;

    always_comb begin
        max_in = '0;
        for (int i = 0; i < NSYM; i++) begin
            if (popcount(m_in[i]) > max_in) begin
                max_in = popcount(m_in[i]);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_tbl
            always_ff @(posedge clk) begin
                if (reset) begin
                    hc_reg[gi]      <= '0;
                    m_reg[gi]       <= '0;
                    len_tbl_reg[gi] <= '0;
                end else if (code_valid) begin
                    hc_reg[gi]      <= hc_in[gi];
                    m_reg[gi]       <= m_in[gi];
                    len_tbl_reg[gi] <= popcount(m_in[gi]);
                end
            end
        end
    endgenerate

    huffman_dec_match u_match (
        .acc      (acc_reg),
        .len      (len_reg),
        .bit_in   (bit_in),
        .max_len  (max_len_reg),
        .hc       (hc_reg),
        .mask     (m_reg),
        .lens     (len_tbl_reg),
        .acc_next (acc_next),
        .len_next (len_next),
        .hit      (hit),
        .idx      (idx),
        .miss     (miss)
    );

    // A table load takes priority over any bit offered in the same cycle.
    assign accept = !code_valid && (state_reg == ST_RUN) && bit_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            len_reg       <= '0;
            max_len_reg   <= '0;
            sym_valid_reg <= 1'b0;
            sym_data_reg  <= '0;
            dec_err_reg   <= 1'b0;
        end else begin
            sym_valid_reg <= 1'b0;
            dec_err_reg   <= 1'b0;
            if (code_valid) begin
                state_reg   <= ST_LOAD;
                acc_reg     <= '0;
                len_reg     <= '0;
                max_len_reg <= max_in;
            end else if (state_reg == ST_LOAD) begin
                state_reg <= (max_len_reg == '0) ? ST_IDLE : ST_RUN;
            end else if (accept) begin
                if (hit) begin
                    sym_valid_reg <= 1'b1;
                    sym_data_reg  <= {5'd0, idx} + 8'd1;
                    acc_reg       <= '0;
                    len_reg       <= '0;
                end else if (miss) begin
                    dec_err_reg <= 1'b1;
                    acc_reg     <= '0;
                    len_reg     <= '0;
                end else begin
                    acc_reg <= acc_next;
                    len_reg <= len_next;
                end
            end
        end
    end

    assign bit_ready = (state_reg == ST_RUN);
    assign sym_valid = sym_valid_reg;
    assign sym_data  = sym_data_reg;
    assign dec_err   = dec_err_reg;

`ifdef HUFF_DEC_STAT_EN
    logic [7:0] scnt_reg [NSYM];

    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_stat
            always_ff @(posedge clk) begin
                if (reset || code_valid) begin
                    scnt_reg[gi] <= '0;
                end else if (accept && hit && (idx == 3'(gi)) && (scnt_reg[gi] != 8'hFF)) begin
                    scnt_reg[gi] <= scnt_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    assign SCNT1 = scnt_reg[0];
    assign SCNT2 = scnt_reg[1];
    assign SCNT3 = scnt_reg[2];
    assign SCNT4 = scnt_reg[3];
    assign SCNT5 = scnt_reg[4];
    assign SCNT6 = scnt_reg[5];
`endif
endmodule
